// File: rtl/cpu_run_ctrl_if.sv
// cpu_run_ctrl_if
// Bundles the run-control request inputs and the status outputs of
// cpu_run_ctrl. clk and reset stay as plain ports on the controller.
//
// Signals:
//   start        one-cycle restart request (controller input)
//   abort        stop request (controller input)
//   cycle_limit  enabled-cycle budget, 0 = unlimited (controller input)
//   halt_pc_en   enable halt-PC stop (controller input)
//   halt_pc      halt address (controller input)
//   pc           current core PC (controller input)
//   cpu_reset    active-high core reset (controller output)
//   cpu_en       core clock enable (controller output)
//   running      high while the core runs (controller output)
//   done         high once a run has stopped (controller output)
//   stop_cause   0 limit, 1 halt-PC, 2 loop, 3 abort (controller output)
//   cycle_count  enabled cycles in the current/last run (controller output)
//   dbg_state    current FSM state (controller output)
//
// Request semantics: there is no ready. start is a single-cycle pulse that
// is acted on only when the controller is in IDLE or DONE and dropped
// otherwise; abort is a level sampled every RESET/RUN cycle and ignored in
// IDLE/DONE. Configuration inputs are only sampled on the accepted start.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32,
  parameter int PC_W  = 32
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cycle_limit;
  logic             halt_pc_en;
  logic [PC_W-1:0]  halt_pc;
  logic [PC_W-1:0]  pc;
  logic             cpu_reset;
  logic             cpu_en;
  logic             running;
  logic             done;
  logic [1:0]       stop_cause;
  logic [CNT_W-1:0] cycle_count;
  logic [1:0]       dbg_state;

  modport master (
    output start, abort, cycle_limit, halt_pc_en, halt_pc, pc,
    input  cpu_reset, cpu_en, running, done, stop_cause, cycle_count,
           dbg_state
  );

  modport slave (
    input  start, abort, cycle_limit, halt_pc_en, halt_pc, pc,
    output cpu_reset, cpu_en, running, done, stop_cause, cycle_count,
           dbg_state
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl
// Run controller for a core: holds the core in reset for RST_CYCLES after
// start, then enables it until a stop condition (abort, halt-PC match,
// self-loop, cycle limit) and reports the cause and executed-cycle count.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset of this block
//   bus    cpu_run_ctrl_if.slave (requests, configuration, status)
//
// cpu_reset/cpu_en/running/done/dbg_state decode the state register only;
// stop_cause and cycle_count are registered.
module cpu_run_ctrl #(
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 2,
  parameter int LOOP_CYCLES = 4,
  parameter int PC_W        = 32
) (
  input  logic           clk,
  input  logic           reset,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int LW = $clog2(LOOP_CYCLES + 1);
  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOP_CYCLES);

  state_e           state_q,       state_d;
  logic [RW-1:0]    rst_cnt_q,     rst_cnt_d;
  logic [CNT_W-1:0] limit_q,       limit_d;
  logic             halt_en_q,     halt_en_d;
  logic [PC_W-1:0]  halt_pc_q,     halt_pc_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;
  logic [1:0]       stop_cause_q,  stop_cause_d;
  logic [PC_W-1:0]  prev_pc_q,     prev_pc_d;
  logic             prev_valid_q,  prev_valid_d;
  logic [LW-1:0]    loop_cnt_q,    loop_cnt_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             pc_same;
  logic [LW-1:0]    loop_cnt_inc;
  logic             loop_hit;
  logic             halt_hit;
  logic             limit_hit;

  // Saturating increment: the count sticks at all-ones.
  assign cnt_inc = (cycle_count_q == '1) ? cycle_count_q
                                         : cycle_count_q + CNT_W'(1);

  // Previous PC is only meaningful after the first RUN cycle of a run.
  assign pc_same      = prev_valid_q && (bus.pc == prev_pc_q);
  assign loop_cnt_inc = pc_same ? loop_cnt_q + LW'(1) : '0;
  assign loop_hit     = pc_same && (loop_cnt_inc == LOOP_LAST);
  assign halt_hit     = halt_en_q && (bus.pc == halt_pc_q);
  // One extra bit so count+1 cannot wrap onto a small limit.
  assign limit_hit    = (limit_q != '0) &&
                        (({1'b0, cycle_count_q} + (CNT_W+1)'(1)) == {1'b0, limit_q});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      rst_cnt_q     <= '0;
      limit_q       <= '0;
      halt_en_q     <= 1'b0;
      halt_pc_q     <= '0;
      cycle_count_q <= '0;
      stop_cause_q  <= 2'd0;
      prev_pc_q     <= '0;
      prev_valid_q  <= 1'b0;
      loop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      limit_q       <= limit_d;
      halt_en_q     <= halt_en_d;
      halt_pc_q     <= halt_pc_d;
      cycle_count_q <= cycle_count_d;
      stop_cause_q  <= stop_cause_d;
      prev_pc_q     <= prev_pc_d;
      prev_valid_q  <= prev_valid_d;
      loop_cnt_q    <= loop_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    rst_cnt_d     = rst_cnt_q;
    limit_d       = limit_q;
    halt_en_d     = halt_en_q;
    halt_pc_d     = halt_pc_q;
    cycle_count_d = cycle_count_q;
    stop_cause_d  = stop_cause_q;
    prev_pc_d     = prev_pc_q;
    prev_valid_d  = prev_valid_q;
    loop_cnt_d    = loop_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d       = S_RESET;
          rst_cnt_d     = '0;
          limit_d       = bus.cycle_limit;
          halt_en_d     = bus.halt_pc_en;
          halt_pc_d     = bus.halt_pc;
          cycle_count_d = '0;
          stop_cause_d  = 2'd0;
          prev_valid_d  = 1'b0;
          loop_cnt_d    = '0;
        end
      end

      S_RESET: begin
        if (bus.abort) begin
          state_d      = S_DONE;
          stop_cause_d = 2'd3;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RW'(1);
        end
      end

      S_RUN: begin
        // The stopping cycle is itself an enabled cycle, so it is counted.
        cycle_count_d = cnt_inc;
        prev_pc_d     = bus.pc;
        prev_valid_d  = 1'b1;
        loop_cnt_d    = loop_cnt_inc;
        if (bus.abort) begin
          state_d      = S_DONE;
          stop_cause_d = 2'd3;
        end else if (halt_hit) begin
          state_d      = S_DONE;
          stop_cause_d = 2'd1;
        end else if (loop_hit) begin
          state_d      = S_DONE;
          stop_cause_d = 2'd2;
        end else if (limit_hit) begin
          state_d      = S_DONE;
          stop_cause_d = 2'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cpu_reset   = (state_q == S_IDLE) || (state_q == S_RESET);
  assign bus.cpu_en      = (state_q == S_RUN);
  assign bus.running     = (state_q == S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.stop_cause  = stop_cause_q;
  assign bus.cycle_count = cycle_count_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Synthesizable run controller placed between the testbench or board clock/reset and the `mips` core. It holds the core in reset for a programmable number of cycles after `start`. It then gates the core's clock enable for a bounded run. The run stops on a cycle limit, a halt-PC match, a self-loop (PC unchanged) or an external abort, and the block reports the stop cause and executed-cycle count. It replaces fixed-count stop sequencing with a parametrised, cause-reporting controller usable in simulation and on hardware.

## Interface
Parameters:
- `CNT_W`, 32: width of cycle counter and `cycle_limit`.
- `RST_CYCLES`, 2: cycles `cpu_reset` is held in RESET state (≥1).
- `LOOP_CYCLES`, 4: consecutive unchanged-PC cycles that signal a self-loop halt (≥1).
- `PC_W`, 32: PC width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset for this block.
- `start`  in  1  one-cycle request to (re)start a run.
- `abort`  in  1  stop an active run immediately.
- `cycle_limit`  in  CNT_W  maximum enabled cycles; 0 = unlimited; sampled at `start`.
- `halt_pc_en`  in  1  enable halt-PC stop; sampled at `start`.
- `halt_pc`  in  PC_W  halt address; sampled at `start`.
- `pc`  in  PC_W  current PC from core.
- `cpu_reset`  out  1  active-high reset to core.
- `cpu_en`  out  1  clock enable to core.
- `running`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `stop_cause`  out  2  0 limit, 1 halt-PC, 2 loop, 3 abort.
- `cycle_count`  out  CNT_W  enabled cycles executed in the current/last run.

## Operation
- States are IDLE, RESET, RUN and DONE.
- IDLE: `cpu_reset`=1, `cpu_en`=0. `start` latches `cycle_limit`/`halt_pc`/`halt_pc_en`, clears `cycle_count`, `stop_cause`, loop tracker; moves to RESET.
- RESET: `cpu_reset`=1, `cpu_en`=0 for exactly RST_CYCLES cycles, then RUN. `abort` here moves to DONE with cause 3, `cycle_count`=0.
- RUN: `cpu_reset`=0, `cpu_en`=1 (decoded from state, not registered). Each RUN cycle increments `cycle_count`, saturating at all-ones with no wrap. Stop conditions are evaluated on that cycle's inputs; the cycle in which a stop condition holds is the last enabled cycle. On stop, the block moves to DONE and records the cause.
  - Abort: `abort`=1.
  - Halt-PC: `halt_pc_en` latched and `pc`==`halt_pc`.
  - Loop: the count of consecutive RUN cycles with `pc` equal to the previous RUN cycle's `pc` reaches LOOP_CYCLES. The first RUN cycle has no valid previous PC and never matches.
  - Limit: latched limit ≠0 and `cycle_count`+1 == limit.
  - Priority when several hold in the same cycle: abort > halt-PC > loop > limit.
- DONE: `cpu_en`=0, `cpu_reset`=0 (core state preserved for inspection), `done`=1. `cycle_count` and `stop_cause` are held. `start` restarts via RESET; `abort` is ignored.
- `start` is ignored in RESET and RUN. `start` and `abort` in the same RUN cycle: abort wins, start is dropped.
- `reset` low at any time (including mid-run) forces IDLE asynchronously.

## Timing
- Reset values: state IDLE, `cpu_reset`=1, `cpu_en`=0, `running`=0, `done`=0, `stop_cause`=0, `cycle_count`=0.
- `start` at edge k: RESET during cycles k+1..k+RST_CYCLES; first `cpu_en`=1 cycle is k+RST_CYCLES+1.
- A limit of N yields exactly N cycles with `cpu_en`=1; `done` rises the cycle after the Nth.
- All outputs other than `cpu_en`/`running`/`done`/`cpu_reset` are registered. Those four decode state, so they change one cycle after the deciding edge with no combinational path from inputs.
- Latency from stop condition to `cpu_en`=0: 1 edge.

## Test plan
- Reset held low 3 cycles, then `start` with limit=10, RST_CYCLES=2 -> `cpu_reset` high for 2 cycles, exactly 10 `cpu_en` cycles, `done`=1, cause 0, `cycle_count`=10.
- halt_pc_en=1, halt_pc=0x0000_3010, `pc` steps by 4 from 0x3000, limit=100 -> 5 enabled cycles, cause 1, count=5.
- Limit 0, `pc` advances to 0x3008 then stays constant, LOOP_CYCLES=4 -> stops after 4 matching cycles (count=7), cause 2.
- `abort` and halt-PC match in the same RUN cycle, with `start` also asserted -> cause 3, DONE, no restart. Later `start` in DONE -> RESET, count cleared.
- `reset` pulled low mid-RUN at count=6 -> immediately `cpu_reset`=1, `cpu_en`=0, count=0, IDLE. `start` in RUN is ignored, with no count clear.
- CNT_W=4, limit 0, no halt -> `cycle_count` saturates at 15 without wrapping; run continues until abort, then cause 3.
